// File: rtl/sram_like_arb.sv
// sram_like_arb: arbitrates NCH SRAM-like request channels onto one downstream
// SRAM-like port using the req / addr_ok / data_ok split-transaction handshake.
// Accepted transactions are recorded in an in-order ID FIFO (up to DEPTH deep)
// so that every downstream data_ok is steered back to the channel that issued it.
//
// Optional feature: define ARB_ROUND_ROBIN_EN to replace the fixed-priority
// unlocked grant (channel 0 highest) with a cyclic round-robin search starting
// at rr_ptr. Locking, FIFO and error behaviour do not change.
module sram_like_arb #(
    parameter int NCH   = 2,
    parameter int AW    = 32,
    parameter int DW    = 32,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [NCH-1:0]          ch_req,
    input  logic [NCH-1:0]          ch_wr,
    input  logic [2*NCH-1:0]        ch_size,
    input  logic [(DW/8)*NCH-1:0]   ch_wstrb,
    input  logic [AW*NCH-1:0]       ch_addr,
    input  logic [DW*NCH-1:0]       ch_wdata,
    output logic [NCH-1:0]          ch_addr_ok,
    output logic [NCH-1:0]          ch_data_ok,
    output logic [DW-1:0]           ch_rdata,
    output logic                    mem_req,
    output logic                    mem_wr,
    output logic [1:0]              mem_size,
    output logic [DW/8-1:0]         mem_wstrb,
    output logic [AW-1:0]           mem_addr,
    output logic [DW-1:0]           mem_wdata,
    input  logic                    mem_addr_ok,
    input  logic                    mem_data_ok,
    input  logic [DW-1:0]           mem_rdata,
    output logic                    busy,
    output logic                    proto_err
);

    localparam int SW  = DW / 8;
    localparam int IDW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int PW  = $clog2(DEPTH);
    localparam int CW  = $clog2(DEPTH + 1);

    // Registered state
    logic [CW-1:0]  count_q,     count_d;
    logic [PW-1:0]  rd_ptr_q,    rd_ptr_d;
    logic [PW-1:0]  wr_ptr_q,    wr_ptr_d;
    logic           lock_q,      lock_d;
    logic [IDW-1:0] lock_id_q,   lock_id_d;
    logic           proto_err_q, proto_err_d;
    logic [IDW-1:0] fifo_q [DEPTH];
    logic [IDW-1:0] fifo_d [DEPTH];
`ifdef ARB_ROUND_ROBIN_EN
    logic [IDW-1:0] rr_ptr_q,    rr_ptr_d;
`endif

    // Combinational helpers
    logic [IDW-1:0] grant_free;
    logic           free_found;
    logic [IDW-1:0] grant;
    logic           granted_req;
    logic           full;
    logic           push;
    logic           pop;
    logic [IDW-1:0] head_id;

    // Unlocked grant: pick one requesting channel (fixed priority or round robin)
    always_comb begin
        grant_free = '0;
        free_found = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        for (int k = 0; k < NCH; k++) begin
            for (int i = 0; i < NCH; i++) begin
                if (!free_found && (i == ((int'(rr_ptr_q) + k) % NCH)) && ch_req[i]) begin
                    grant_free = IDW'(i);
                    free_found = 1'b1;
                end
            end
        end
`else
        for (int i = 0; i < NCH; i++) begin
            if (!free_found && ch_req[i]) begin
                grant_free = IDW'(i);
                free_found = 1'b1;
            end
        end
`endif
    end

    // A stalled request keeps its channel until accepted so the presented fields never change
    always_comb begin
        grant = lock_q ? lock_id_q : grant_free;
    end

    // Route the granted channel's request and fields to the downstream port
    always_comb begin
        granted_req = 1'b0;
        mem_wr      = 1'b0;
        mem_size    = '0;
        mem_wstrb   = '0;
        mem_addr    = '0;
        mem_wdata   = '0;
        for (int i = 0; i < NCH; i++) begin
            if (grant == IDW'(i)) begin
                granted_req = ch_req[i];
                mem_wr      = ch_wr[i];
                mem_size    = ch_size[2*i +: 2];
                mem_wstrb   = ch_wstrb[SW*i +: SW];
                mem_addr    = ch_addr[AW*i +: AW];
                mem_wdata   = ch_wdata[DW*i +: DW];
            end
        end
    end

    // Handshake qualifiers: a request only goes out while a FIFO slot is free,
    // and a locked channel that drops its req withdraws the downstream request
    always_comb begin
        full    = (count_q == CW'(DEPTH));
        mem_req = granted_req & ~full;
        push    = mem_req & mem_addr_ok;
        pop     = mem_data_ok & (count_q != '0);
        head_id = fifo_q[rd_ptr_q];
    end

    // Upstream acknowledgements: accept goes to the grant, response to the FIFO head
    always_comb begin
        ch_addr_ok = '0;
        ch_data_ok = '0;
        for (int i = 0; i < NCH; i++) begin
            if (push && (grant == IDW'(i))) begin
                ch_addr_ok[i] = 1'b1;
            end
            if (pop && (head_id == IDW'(i))) begin
                ch_data_ok[i] = 1'b1;
            end
        end
        ch_rdata = mem_rdata;
    end

    // Next-state for the ID FIFO, its pointers and the occupancy count
    always_comb begin
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            fifo_d[wr_ptr_q] = grant;
            wr_ptr_d         = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        count_d = count_q + CW'(push) - CW'(pop);
    end

    // Next-state for the request lock: set on a stall, cleared on accept or withdrawn req
    always_comb begin
        lock_d    = lock_q;
        lock_id_d = lock_id_q;
        if (mem_req && !mem_addr_ok) begin
            lock_d    = 1'b1;
            lock_id_d = grant;
        end else if (push) begin
            lock_d = 1'b0;
        end else if (lock_q && !granted_req) begin
            lock_d = 1'b0;
        end
    end

    // A response with nothing outstanding is a protocol error that stays set until reset
    always_comb begin
        proto_err_d = proto_err_q | (mem_data_ok & (count_q == '0));
    end

`ifdef ARB_ROUND_ROBIN_EN
    // Round-robin pointer moves just past the channel that was accepted
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (push) begin
            rr_ptr_d = (grant == IDW'(NCH - 1)) ? '0 : grant + IDW'(1);
        end
    end
`endif

    // State registers, cleared asynchronously; anything in flight at reset is forgotten
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count_q     <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            lock_q      <= 1'b0;
            lock_id_q   <= '0;
            proto_err_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
`ifdef ARB_ROUND_ROBIN_EN
            rr_ptr_q    <= '0;
`endif
        end else begin
            count_q     <= count_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            lock_q      <= lock_d;
            lock_id_q   <= lock_id_d;
            proto_err_q <= proto_err_d;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_q[i] <= fifo_d[i];
            end
`ifdef ARB_ROUND_ROBIN_EN
            rr_ptr_q    <= rr_ptr_d;
`endif
        end
    end

    // Status outputs come straight from registered state
    always_comb begin
        busy      = (count_q != '0);
        proto_err = proto_err_q;
    end

endmodule

// File: tb/tb_sram_like_arb.sv
// tb_sram_like_arb: table-driven bench for sram_like_arb (NCH=2, DEPTH=4).
// Each vector is one clock cycle: inputs are driven on the falling edge and
// outputs sampled shortly after, well before the next rising edge. Expected
// data_ok routing comes from a scoreboard queue fed by the expected accepts.
module tb_sram_like_arb;

    localparam int NCH   = 2;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 4;

    localparam logic [31:0] ADDR0  = 32'h0000_1000;
    localparam logic [31:0] ADDR1  = 32'h1C00_0000;
    localparam logic [31:0] WDATA0 = 32'h0BAD_F00D;
    localparam logic [31:0] WDATA1 = 32'hDEAD_BEEF;

    logic                  clk;
    logic                  resetn;
    logic [NCH-1:0]        ch_req;
    logic [NCH-1:0]        ch_wr;
    logic [2*NCH-1:0]      ch_size;
    logic [(DW/8)*NCH-1:0] ch_wstrb;
    logic [AW*NCH-1:0]     ch_addr;
    logic [DW*NCH-1:0]     ch_wdata;
    logic [NCH-1:0]        ch_addr_ok;
    logic [NCH-1:0]        ch_data_ok;
    logic [DW-1:0]         ch_rdata;
    logic                  mem_req;
    logic                  mem_wr;
    logic [1:0]            mem_size;
    logic [DW/8-1:0]       mem_wstrb;
    logic [AW-1:0]         mem_addr;
    logic [DW-1:0]         mem_wdata;
    logic                  mem_addr_ok;
    logic                  mem_data_ok;
    logic [DW-1:0]         mem_rdata;
    logic                  busy;
    logic                  proto_err;

    typedef struct {
        logic [1:0]  req;
        logic        aok;
        logic        dok;
        logic [31:0] rdata;
        logic        exp_mreq;
        logic [1:0]  exp_aok;
        logic        exp_busy;
        logic        exp_perr;
        int          exp_gnt;
    } vec_t;

    int   compared   = 0;
    int   mismatched = 0;
    int   sb[$];
    vec_t vecs[$];
    logic [1:0] rr_second;

    sram_like_arb #(.NCH(NCH), .AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .resetn(resetn),
        .ch_req(ch_req), .ch_wr(ch_wr), .ch_size(ch_size), .ch_wstrb(ch_wstrb),
        .ch_addr(ch_addr), .ch_wdata(ch_wdata),
        .ch_addr_ok(ch_addr_ok), .ch_data_ok(ch_data_ok), .ch_rdata(ch_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
        .busy(busy), .proto_err(proto_err)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t mk(input logic [1:0] req, input logic aok, input logic dok,
                                input logic [31:0] rdata, input logic exp_mreq,
                                input logic [1:0] exp_aok, input logic exp_busy,
                                input logic exp_perr, input int exp_gnt);
        vec_t v;
        v.req = req; v.aok = aok; v.dok = dok; v.rdata = rdata;
        v.exp_mreq = exp_mreq; v.exp_aok = exp_aok; v.exp_busy = exp_busy;
        v.exp_perr = exp_perr; v.exp_gnt = exp_gnt;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One cycle: drive, settle, compare against the vector and the scoreboard
    task automatic applyStimulus(input vec_t v, input string tag);
        logic [1:0] exp_dok;
        @(negedge clk);
        ch_req      = v.req;
        mem_addr_ok = v.aok;
        mem_data_ok = v.dok;
        mem_rdata   = v.rdata;
        #2;
        exp_dok = 2'b00;
        if (v.dok && sb.size() > 0) begin
            exp_dok = (sb.pop_front() == 0) ? 2'b01 : 2'b10;
        end
        if (v.exp_aok[0]) sb.push_back(0);
        else if (v.exp_aok[1]) sb.push_back(1);
        checkOutput({tag, " mem_req"},    32'(mem_req),    32'(v.exp_mreq));
        checkOutput({tag, " ch_addr_ok"}, 32'(ch_addr_ok), 32'(v.exp_aok));
        checkOutput({tag, " ch_data_ok"}, 32'(ch_data_ok), 32'(exp_dok));
        checkOutput({tag, " busy"},       32'(busy),       32'(v.exp_busy));
        checkOutput({tag, " proto_err"},  32'(proto_err),  32'(v.exp_perr));
        if (exp_dok != 2'b00) begin
            checkOutput({tag, " ch_rdata"}, ch_rdata, v.rdata);
        end
        if (v.exp_mreq) begin
            checkOutput({tag, " mem_addr"}, mem_addr, (v.exp_gnt == 1) ? ADDR1 : ADDR0);
            checkOutput({tag, " mem_wr"},   32'(mem_wr), (v.exp_gnt == 1) ? 32'd1 : 32'd0);
            checkOutput({tag, " mem_wdata"}, mem_wdata, (v.exp_gnt == 1) ? WDATA1 : WDATA0);
        end
    endtask

    // Assert reset mid-cycle and check the asynchronously cleared outputs
    task automatic doReset(input string tag);
        @(negedge clk);
        ch_req      = '0;
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b0;
        mem_rdata   = '0;
        resetn      = 1'b0;
        #2;
        checkOutput({tag, " mem_req"},    32'(mem_req),    32'd0);
        checkOutput({tag, " busy"},       32'(busy),       32'd0);
        checkOutput({tag, " proto_err"},  32'(proto_err),  32'd0);
        checkOutput({tag, " ch_addr_ok"}, 32'(ch_addr_ok), 32'd0);
        checkOutput({tag, " ch_data_ok"}, 32'(ch_data_ok), 32'd0);
        sb.delete();
        @(negedge clk);
        resetn = 1'b1;
    endtask

    initial begin
        resetn      = 1'b0;
        ch_req      = '0;
        ch_wr       = 2'b10;
        ch_size     = 4'b1010;
        ch_wstrb    = 8'hF0;
        ch_addr     = {ADDR1, ADDR0};
        ch_wdata    = {WDATA1, WDATA0};
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b0;
        mem_rdata   = '0;

        // Collision: both request, ch0 first, then ch1; responses in order
        vecs.push_back(mk(2'b11, 1, 0, 32'h0,         1, 2'b01, 0, 0, 0));
        vecs.push_back(mk(2'b10, 1, 0, 32'h0,         1, 2'b10, 1, 0, 1));
        vecs.push_back(mk(2'b00, 0, 1, 32'h1111_1111, 0, 2'b00, 1, 0, 0));
        vecs.push_back(mk(2'b00, 0, 1, 32'h2222_2222, 0, 2'b00, 1, 0, 0));
        vecs.push_back(mk(2'b00, 0, 0, 32'h0,         0, 2'b00, 0, 0, 0));
        // Lock: ch1 stalls, ch0 joins, ch1 must still win
        vecs.push_back(mk(2'b10, 0, 0, 32'h0,         1, 2'b00, 0, 0, 1));
        vecs.push_back(mk(2'b11, 0, 0, 32'h0,         1, 2'b00, 0, 0, 1));
        vecs.push_back(mk(2'b11, 0, 0, 32'h0,         1, 2'b00, 0, 0, 1));
        vecs.push_back(mk(2'b11, 1, 0, 32'h0,         1, 2'b10, 0, 0, 1));
        vecs.push_back(mk(2'b01, 1, 0, 32'h0,         1, 2'b01, 1, 0, 0));
        vecs.push_back(mk(2'b00, 0, 1, 32'h3333_3333, 0, 2'b00, 1, 0, 0));
        vecs.push_back(mk(2'b00, 0, 1, 32'h4444_4444, 0, 2'b00, 1, 0, 0));
        vecs.push_back(mk(2'b00, 0, 0, 32'h0,         0, 2'b00, 0, 0, 0));
        // Full: four accepts, then blocked, pop frees a slot a cycle later
        vecs.push_back(mk(2'b01, 1, 0, 32'h0,         1, 2'b01, 0, 0, 0));
        vecs.push_back(mk(2'b01, 1, 0, 32'h0,         1, 2'b01, 1, 0, 0));
        vecs.push_back(mk(2'b01, 1, 0, 32'h0,         1, 2'b01, 1, 0, 0));
        vecs.push_back(mk(2'b01, 1, 0, 32'h0,         1, 2'b01, 1, 0, 0));
        vecs.push_back(mk(2'b01, 1, 0, 32'h0,         0, 2'b00, 1, 0, 0));
        vecs.push_back(mk(2'b01, 1, 1, 32'h5555_5555, 0, 2'b00, 1, 0, 0));
        vecs.push_back(mk(2'b01, 1, 0, 32'h0,         1, 2'b01, 1, 0, 0));
        for (int k = 0; k < 4; k++) begin
            vecs.push_back(mk(2'b00, 0, 1, 32'h6000_0000 + 32'(k), 0, 2'b00, 1, 0, 0));
        end
        vecs.push_back(mk(2'b00, 0, 0, 32'h0,         0, 2'b00, 0, 0, 0));
        // Ordering with a simultaneous accept and response
        vecs.push_back(mk(2'b01, 1, 0, 32'h0,         1, 2'b01, 0, 0, 0));
        vecs.push_back(mk(2'b10, 1, 0, 32'h0,         1, 2'b10, 1, 0, 1));
        vecs.push_back(mk(2'b01, 1, 1, 32'h7777_7777, 1, 2'b01, 1, 0, 0));
        vecs.push_back(mk(2'b00, 0, 1, 32'h8888_8888, 0, 2'b00, 1, 0, 0));
        vecs.push_back(mk(2'b00, 0, 1, 32'h9999_9999, 0, 2'b00, 1, 0, 0));
        vecs.push_back(mk(2'b00, 0, 0, 32'h0,         0, 2'b00, 0, 0, 0));
        // Error: response with nothing outstanding, sticky afterwards
        vecs.push_back(mk(2'b00, 0, 1, 32'hABCD_ABCD, 0, 2'b00, 0, 0, 0));
        vecs.push_back(mk(2'b00, 0, 0, 32'h0,         0, 2'b00, 0, 1, 0));
        vecs.push_back(mk(2'b01, 1, 0, 32'h0,         1, 2'b01, 0, 1, 0));
        vecs.push_back(mk(2'b00, 0, 1, 32'h1234_5678, 0, 2'b00, 1, 1, 0));
        vecs.push_back(mk(2'b00, 0, 0, 32'h0,         0, 2'b00, 0, 1, 0));

        doReset("reset0");
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i], $sformatf("v%0d", i));
        end

        // A transaction outstanding at reset is forgotten; its response is an error
        doReset("reset1");
        applyStimulus(mk(2'b01, 1, 0, 32'h0, 1, 2'b01, 0, 0, 0), "f0");
        applyStimulus(mk(2'b00, 0, 0, 32'h0, 0, 2'b00, 1, 0, 0), "f1");
        doReset("reset2");
        applyStimulus(mk(2'b00, 0, 1, 32'hFEED_FACE, 0, 2'b00, 0, 0, 0), "f2");
        applyStimulus(mk(2'b00, 0, 0, 32'h0,         0, 2'b00, 0, 1, 0), "f3");

        // Both channels held requesting: alternate under round robin, ch0 only otherwise
        doReset("reset3");
`ifdef ARB_ROUND_ROBIN_EN
        rr_second = 2'b10;
`else
        rr_second = 2'b01;
`endif
        for (int k = 0; k < 4; k++) begin
            logic [1:0] ea;
            ea = (k % 2 == 0) ? 2'b01 : rr_second;
            applyStimulus(mk(2'b11, 1, 0, 32'h0, 1, ea, (k != 0), 0, (ea == 2'b10) ? 1 : 0),
                          $sformatf("rr%0d", k));
        end
        for (int k = 0; k < 4; k++) begin
            applyStimulus(mk(2'b00, 0, 1, 32'hC000_0000 + 32'(k), 0, 2'b00, 1, 0, 0),
                          $sformatf("rrd%0d", k));
        end
        applyStimulus(mk(2'b00, 0, 0, 32'h0, 0, 2'b00, 0, 0, 0), "rr_idle");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/sram_like_arb.md
Name: sram_like_arb

Overview:
- Arbitrates NCH upstream SRAM-like request channels onto one downstream SRAM-like port. Channels include the instruction fetch and the data access ports of the core.
- Uses the req / addr_ok / data_ok split-transaction handshake.
- Tracks up to DEPTH outstanding transactions in an in-order ID FIFO, so each data_ok is routed back to the channel that issued it.
- Sits between the core pipeline and the downstream memory bridge.

Parameters:
NCH, 2, number of upstream channels (1..8); channel 0 is highest fixed priority.
AW, 32, address width.
DW, 32, data width; strobe width is DW/8.
DEPTH, 4, maximum outstanding accepted-but-unanswered transactions (power of 2, ≥2).

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
ch_req  in  NCH  per-channel request
ch_wr  in  NCH  per-channel write flag
ch_size  in  2*NCH  per-channel size (0=byte, 1=half, 2=word)
ch_wstrb  in  (DW/8)*NCH  per-channel byte strobes
ch_addr  in  AW*NCH  per-channel address
ch_wdata  in  DW*NCH  per-channel write data
ch_addr_ok  out  NCH  request accepted, one-hot or zero
ch_data_ok  out  NCH  response for that channel, one-hot or zero
ch_rdata  out  DW  read data, broadcast; valid with ch_data_ok
mem_req  out  1  downstream request
mem_wr  out  1  downstream write flag
mem_size  out  2  downstream size
mem_wstrb  out  DW/8  downstream strobes
mem_addr  out  AW  downstream address
mem_wdata  out  DW  downstream write data
mem_addr_ok  in  1  downstream accepts request
mem_data_ok  in  1  downstream response
mem_rdata  in  DW  downstream read data
busy  out  1  at least one transaction outstanding
proto_err  out  1  sticky: data_ok received with FIFO empty

Behaviour:
- Reset: clearing is asynchronous on resetn low.
  - Cleared state: count=0, rd_ptr=0, wr_ptr=0, lock=0, lock_id=0, proto_err=0, rr_ptr=0.
  - busy=0; mem_req=0; ch_addr_ok=0; ch_data_ok=0.
  - An outstanding downstream transaction present at reset is forgotten; its later data_ok counts as a protocol error.
- Grant:
  - full = (count==DEPTH).
  - If lock=1, grant=lock_id.
  - Otherwise grant = lowest-index asserted ch_req bit (fixed priority).
- Downstream request:
  - mem_req = |ch_req & ~full, combinational.
  - mem_wr, mem_size, mem_wstrb, mem_addr and mem_wdata are muxed from the granted channel.
- Request stability:
  - If mem_req=1 and mem_addr_ok=0, then lock<=1 and lock_id<=grant next cycle, so the presented request cannot change.
  - On acceptance, lock<=0.
  - Upstream channels must hold req and their fields until addr_ok; the arbiter never drops a presented request.
  - If a locked channel deasserts req, this is a protocol violation: mem_req drops and lock clears.
- Accept: when mem_req & mem_addr_ok, ch_addr_ok[grant]=1 in the same cycle, and grant is pushed to fifo[wr_ptr] with wr_ptr+1 (mod DEPTH).
- Response:
  - When mem_data_ok & count!=0, ch_data_ok[fifo[rd_ptr]]=1 in the same cycle, ch_rdata=mem_rdata, and rd_ptr+1 (mod DEPTH).
  - Latency from mem_data_ok to ch_data_ok is 0 cycles (combinational).
- Count: next count = count + push − pop.
  - Simultaneous push and pop leaves count unchanged.
  - When full, push is impossible (mem_req=0) even if a pop occurs in the same cycle; the slot frees next cycle.
- Same-cycle accept and response for the same channel: both ch_addr_ok and ch_data_ok may assert together, since the response belongs to an older transaction.
- Error: mem_data_ok while count==0 sets proto_err=1 (sticky until reset). No pop occurs and ch_data_ok stays 0.
- busy = (count!=0), registered-derived.
- Pointers wrap naturally at DEPTH.

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- Defined: the unlocked grant is the first requesting channel at or after rr_ptr, searching cyclically. On each accept, rr_ptr <= grant+1 (mod NCH). Any continuously requesting channel is granted within NCH accepts.
- Undefined: fixed priority, channel 0 highest; rr_ptr is absent.
- Locking, FIFO and error behaviour are identical in both cases.

Test Plan:
- Reset/idle: resetn=0 then 1, with all ch_req=0 → mem_req=0, busy=0, proto_err=0, all ok outputs 0.
- Collision: ch_req=2'b11, mem_addr_ok=1 for 2 cycles, then two mem_data_ok pulses → ch_addr_ok=01 then 10; ch_data_ok=01 then 10, with ch_rdata matching mem_rdata 0x1111_1111 and 0x2222_2222.
- Lock: ch1 requests addr 0x1C00_0000 and mem_addr_ok=0 for 3 cycles; ch0 raises req at cycle 1 → mem_addr stays 0x1C00_0000 and ch_addr_ok[1] asserts first when addr_ok=1.
- Full: DEPTH=4, accept 4 requests with no data_ok → busy=1 and mem_req=0 on the 5th. Pulse one data_ok → mem_req=1 the next cycle; count stays ≤4 throughout.
- Ordering: accept ch0, ch1, ch0, then 3 data_ok pulses including one cycle with a simultaneous accept → ch_data_ok sequence 01, 10, 01, and count correct.
- Error/RR: mem_data_ok with count=0 → proto_err=1 and ch_data_ok=0. With ARB_ROUND_ROBIN_EN and ch_req=11 held with addr_ok=1 for 4 cycles → grants alternate 0, 1, 0, 1.
